// File: rtl/matrix_store.sv
// Write-back stage for 4x4 matrix results: captures a packed 16x16-bit matrix
// on start and streams its elements as address/data beats over valid/ready.
module matrix_store #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [255:0]      m_in,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              col_major,
  output logic              busy,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [255:0]      mat;
  logic [ADDR_W-1:0] base;
  logic              cm;
  logic [3:0]        idx;
  logic [3:0]        idx_nxt;

  assign idx_nxt = idx + 4'd1;

  // Beat index -> element (r,c); element (r,c) sits at bit offset (r*4+c)*16.
  function automatic logic [15:0] elem_at(input logic [255:0] m,
                                          input logic [3:0]   i,
                                          input logic         colm);
    logic [1:0] r;
    logic [1:0] c;
    logic [7:0] lsb;
    if (colm) begin
      c = i[3:2];
      r = i[1:0];
    end else begin
      r = i[3:2];
      c = i[1:0];
    end
    lsb = {r, c, 4'b0000};
    return m[lsb +: 16];
  endfunction

  // Single FSM with registered outputs; next beat's addr/data are prepared
  // on acceptance so the outputs hold stable through any stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      mat      <= 256'd0;
      base     <= '0;
      cm       <= 1'b0;
      idx      <= 4'd0;
      busy     <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= 16'd0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mat      <= m_in;
            base     <= base_addr;
            cm       <= col_major;
            idx      <= 4'd0;
            state    <= SEND;
            busy     <= 1'b1;
            wr_valid <= 1'b1;
            wr_addr  <= base_addr;
            wr_data  <= m_in[15:0];  // element (0,0) leads in either order
          end
        end
        SEND: begin
          if (wr_ready) begin
            if (idx == 4'd15) begin
              state    <= DONE;
              wr_valid <= 1'b0;
              wr_addr  <= '0;
              wr_data  <= 16'd0;
              done     <= 1'b1;
            end else begin
              idx     <= idx_nxt;
              wr_addr <= base + ADDR_W'(idx_nxt);
              wr_data <= elem_at(mat, idx_nxt, cm);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          idx   <= 4'd0;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          wr_valid <= 1'b0;
          wr_addr  <= '0;
          wr_data  <= 16'd0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_store.sv
// Directed self-checking bench for matrix_store: ordering, backpressure,
// address wrap, ignored start, mid-transfer reset and capture isolation.
module tb_matrix_store;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [255:0] m_in;
  logic [7:0]   base_addr;
  logic         col_major;
  logic         busy;
  logic         wr_valid;
  logic         wr_ready;
  logic [7:0]   wr_addr;
  logic [15:0]  wr_data;
  logic         done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  matrix_store #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .m_in(m_in),
    .base_addr(base_addr), .col_major(col_major), .busy(busy),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .done(done)
  );

  // Element (r,c) = off + r*16 + c.
  function automatic logic [255:0] make_mat(input logic [15:0] off);
    logic [255:0] m;
    m = 256'd0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[(r*4+c)*16 +: 16] = off + 16'(r*16 + c);
    return m;
  endfunction

  function automatic logic [15:0] exp_elem(input int k, input bit cmaj, input logic [15:0] off);
    int r;
    int c;
    r = cmaj ? (k % 4) : (k / 4);
    c = cmaj ? (k / 4) : (k % 4);
    return off + 16'(r*16 + c);
  endfunction

  task automatic kick(input logic [255:0] m, input logic [7:0] b, input logic cmaj);
    @(negedge clk);
    m_in = m; base_addr = b; col_major = cmaj; start = 1'b1; wr_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; m_in = 256'd0; base_addr = 8'd0;
    col_major = 1'b0; wr_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, wr_valid, wr_addr, wr_data, done} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0", {busy, wr_valid, wr_addr, wr_data, done});
    end
    reset = 1'b0;
  endtask

  task automatic test_order(input bit cmaj, input logic [7:0] b, input string name);
    kick(make_mat(16'h0100), b, cmaj);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if ({busy, wr_valid, done} !== 3'b110 || wr_addr !== b + 8'(k) ||
          wr_data !== exp_elem(k, cmaj, 16'h0100)) begin
        errors++;
        $display("FAIL %s beat%0d got v=%b d=%b a=%h data=%h exp a=%h data=%h", name, k,
                 wr_valid, done, wr_addr, wr_data, b + 8'(k), exp_elem(k, cmaj, 16'h0100));
      end
      @(negedge clk);
    end
    checks++;
    if ({busy, wr_valid, done, wr_addr, wr_data} !== {3'b101, 24'd0}) begin
      errors++;
      $display("FAIL %s done_cycle got b=%b v=%b d=%b exp 1 0 1", name, busy, wr_valid, done);
    end
    @(negedge clk);
    checks++;
    if ({busy, wr_valid, done} !== 3'b000) begin
      errors++;
      $display("FAIL %s idle_after got b=%b v=%b d=%b exp 0 0 0", name, busy, wr_valid, done);
    end
  endtask

  task automatic test_backpressure;
    int stalls [16];
    logic [15:0] hold;
    foreach (stalls[i]) stalls[i] = 0;
    stalls[0] = 1; stalls[5] = 1; stalls[15] = 3;
    kick(make_mat(16'h0100), 8'h60, 1'b0);
    for (int k = 0; k < 16; k++) begin
      for (int s = 0; s <= stalls[k]; s++) begin
        checks++;
        hold = exp_elem(k, 1'b0, 16'h0100);
        if (wr_valid !== 1'b1 || wr_addr !== 8'h60 + 8'(k) || wr_data !== hold || done !== 1'b0) begin
          errors++;
          $display("FAIL bp beat%0d stall%0d got v=%b a=%h data=%h exp a=%h data=%h", k, s,
                   wr_valid, wr_addr, wr_data, 8'h60 + 8'(k), hold);
        end
        wr_ready = (s < stalls[k]) ? 1'b0 : 1'b1;
        @(negedge clk);
      end
    end
    checks++;  // cycle 22
    if (done !== 1'b1 || wr_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp done_cycle22 got d=%b v=%b exp 1 0", done, wr_valid);
    end
    wr_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_wrap_ignored_start;
    int dones;
    dones = 0;
    kick(make_mat(16'h0100), 8'hFC, 1'b0);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (wr_valid !== 1'b1 || wr_addr !== 8'hFC + 8'(k) || wr_data !== exp_elem(k, 1'b0, 16'h0100)) begin
        errors++;
        $display("FAIL wrap beat%0d got a=%h data=%h exp a=%h data=%h", k, wr_addr, wr_data,
                 8'hFC + 8'(k), exp_elem(k, 1'b0, 16'h0100));
      end
      if (k == 3) begin
        start = 1'b1; m_in = make_mat(16'h0A00); base_addr = 8'h33;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones !== 1 || wr_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wrap single_done got dones=%0d v=%b b=%b exp 1 0 0", dones, wr_valid, busy);
    end
  endtask

  task automatic test_mid_reset;
    kick(make_mat(16'h0100), 8'h80, 1'b0);
    repeat (7) @(negedge clk);
    checks++;
    if (wr_addr !== 8'h87 || wr_data !== 16'h0113) begin
      errors++;
      $display("FAIL mreset beat7 got a=%h data=%h exp 87 0113", wr_addr, wr_data);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, wr_valid, wr_addr, wr_data, done} !== 27'd0) begin
      errors++;
      $display("FAIL mreset zeros got=%h exp=0", {busy, wr_valid, wr_addr, wr_data, done});
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || wr_valid !== 1'b0) begin
        errors++;
        $display("FAIL mreset no_done got d=%b v=%b exp 0 0", done, wr_valid);
      end
    end
    test_order(1'b0, 8'h90, "after_reset");
  endtask

  task automatic test_input_change;
    kick(make_mat(16'h0200), 8'hA0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (wr_data !== exp_elem(k, 1'b1, 16'h0200) || wr_addr !== 8'hA0 + 8'(k)) begin
        errors++;
        $display("FAIL inchg beat%0d got a=%h data=%h exp a=%h data=%h", k, wr_addr, wr_data,
                 8'hA0 + 8'(k), exp_elem(k, 1'b1, 16'h0200));
      end
      m_in = {8{$urandom()}}; base_addr = 8'($urandom()); col_major = ~col_major;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    kick(make_mat(16'h0100), 8'h00, 1'b0);
    repeat (17) @(negedge clk);
    checks++;  // cycle 18
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b busy_c18 got=%b exp=0", busy);
    end
    m_in = make_mat(16'h0300); base_addr = 8'hC0; col_major = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (wr_valid !== 1'b1 || wr_addr !== 8'hC0 || wr_data !== 16'h0300) begin
      errors++;
      $display("FAIL b2b restart got v=%b a=%h data=%h exp 1 c0 0300", wr_valid, wr_addr, wr_data);
    end
    repeat (18) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_order(1'b0, 8'h10, "row_major");
    test_order(1'b1, 8'h40, "col_major");
    test_backpressure();
    test_wrap_ignored_start();
    test_mid_reset();
    test_input_change();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
